// File: rtl/img_arb_pkg.sv
// Shared types and constants for the image RAM arbiter: owner encoding,
// return-tag layout and address/pixel widths.
package img_arb_pkg;

  localparam int IMG_ADDR_W = 15;
  localparam int PIX_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VGA_RD = 2'd1,
    AES_RD = 2'd2,
    AES_WR = 2'd3
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   oor;
  } tag_t;

  localparam int   TAG_W    = $bits(tag_t);
  localparam tag_t TAG_NONE = '{owner: IDLE, oor: 1'b0};

endpackage

// File: rtl/img_arb_tag_pipe.sv
// Read-return path: delays the issue tag by MEM_LAT cycles so it lines up
// with mem_rdata, then registers the data into the owning requester's port.
module img_arb_tag_pipe
  import img_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic [PIX_W-1:0] vga_data,
  output logic             vga_valid,
  output logic [PIX_W-1:0] aes_rdata,
  output logic             aes_rvalid
);

  tag_t             pipe_q [MEM_LAT];
  tag_t             pipe_d [MEM_LAT];
  tag_t             exit_tag;
  logic [PIX_W-1:0] ret_data;
  logic [PIX_W-1:0] vga_data_q, vga_data_d;
  logic [PIX_W-1:0] aes_rdata_q, aes_rdata_d;
  logic             vga_valid_q, vga_valid_d;
  logic             aes_rvalid_q, aes_rvalid_d;

  always_comb begin
    pipe_d[0] = tag_t'(tag_in);
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Out-of-range reads were issued at address 0; their data is masked here.
  assign exit_tag = pipe_q[MEM_LAT-1];
  assign ret_data = exit_tag.oor ? '0 : mem_rdata;

  always_comb begin
    vga_valid_d  = (exit_tag.owner == VGA_RD);
    aes_rvalid_d = (exit_tag.owner == AES_RD);
    vga_data_d   = vga_valid_d  ? ret_data : vga_data_q;
    aes_rdata_d  = aes_rvalid_d ? ret_data : aes_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_q[i] <= TAG_NONE;
      end
      vga_data_q   <= '0;
      aes_rdata_q  <= '0;
      vga_valid_q  <= 1'b0;
      aes_rvalid_q <= 1'b0;
    end else begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      vga_data_q   <= vga_data_d;
      aes_rdata_q  <= aes_rdata_d;
      vga_valid_q  <= vga_valid_d;
      aes_rvalid_q <= aes_rvalid_d;
    end
  end

  assign vga_data   = vga_data_q;
  assign vga_valid  = vga_valid_q;
  assign aes_rdata  = aes_rdata_q;
  assign aes_rvalid = aes_rvalid_q;

endmodule

// File: rtl/img_mem_arbiter.sv
// Single-port image RAM arbiter: VGA reads have absolute priority, AES reads/writes
// fill the gaps. Define IMG_ARB_STATS_EN to add per-frame access counters.
module img_mem_arbiter
  import img_arb_pkg::*;
#(
  parameter int IMG_WIDTH  = 175,
  parameter int IMG_HEIGHT = 175,
  parameter int IMG_PIXELS = IMG_WIDTH * IMG_HEIGHT,
  parameter int MEM_LAT    = 1,
  parameter int MAX_WAIT   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vga_req,
  input  logic [IMG_ADDR_W-1:0] vga_addr,
  output logic [PIX_W-1:0]      vga_data,
  output logic                  vga_valid,
  input  logic                  aes_req,
  input  logic                  aes_we,
  input  logic [IMG_ADDR_W-1:0] aes_addr,
  input  logic [PIX_W-1:0]      aes_wdata,
  output logic                  aes_gnt,
  output logic [PIX_W-1:0]      aes_rdata,
  output logic                  aes_rvalid,
  output logic                  aes_starve,
  input  logic                  stat_clr,
  output logic [IMG_ADDR_W-1:0] mem_addr,
  output logic                  mem_we,
  output logic [PIX_W-1:0]      mem_wdata,
  input  logic [PIX_W-1:0]      mem_rdata
`ifdef IMG_ARB_STATS_EN
  ,
  input  logic                  frame_start,
  output logic [15:0]           vga_cnt,
  output logic [15:0]           aes_rd_cnt,
  output logic [15:0]           aes_wr_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam logic [IMG_ADDR_W-1:0] ADDR_LIMIT = IMG_ADDR_W'(IMG_PIXELS);
  localparam logic [7:0]            WAIT_MAX   = 8'(MAX_WAIT);

  owner_e                state_q, state_d;
  logic [IMG_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [PIX_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic                  oor_q, oor_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  starve_q, starve_d;
  logic                  vga_oor, aes_oor;
  tag_t                  issue_tag;

  assign vga_oor = (vga_addr >= ADDR_LIMIT);
  assign aes_oor = (aes_addr >= ADDR_LIMIT);
  assign aes_gnt = rst_n & aes_req & ~vga_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      oor_q       <= 1'b0;
      wait_cnt_q  <= '0;
      starve_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      oor_q       <= oor_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
    end
  end

  // The next owner depends only on this cycle's requests, never on the current state.
  always_comb begin
    state_d = IDLE;
    if (vga_req) begin
      state_d = VGA_RD;
    end else if (aes_gnt) begin
      state_d = aes_we ? AES_WR : AES_RD;
    end
  end

  always_comb begin
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    oor_d       = 1'b0;
    unique case (state_d)
      VGA_RD: begin
        oor_d      = vga_oor;
        mem_addr_d = vga_oor ? '0 : vga_addr;
      end
      AES_RD: begin
        oor_d      = aes_oor;
        mem_addr_d = aes_oor ? '0 : aes_addr;
      end
      AES_WR: begin
        oor_d       = aes_oor;
        mem_addr_d  = aes_oor ? '0 : aes_addr;
        mem_we_d    = ~aes_oor;
        mem_wdata_d = aes_wdata;
      end
      default: ;
    endcase
  end

  // Clear beats a coincident set so software never misses a clear.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    starve_d   = starve_q;
    if (stat_clr || !aes_req || aes_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    if (stat_clr) begin
      starve_d = 1'b0;
    end else if (wait_cnt_d == WAIT_MAX) begin
      starve_d = 1'b1;
    end
  end

  always_comb begin
    issue_tag.owner = (state_q == AES_WR) ? IDLE : state_q;
    issue_tag.oor   = oor_q;
  end

  img_arb_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .tag_in     (issue_tag),
    .mem_rdata  (mem_rdata),
    .vga_data   (vga_data),
    .vga_valid  (vga_valid),
    .aes_rdata  (aes_rdata),
    .aes_rvalid (aes_rvalid)
  );

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign aes_starve = starve_q;

`ifdef IMG_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic [3:0][15:0] cnt_q, cnt_d;
  logic [3:0][15:0] out_q, out_d;
  logic [3:0]       hit;

  assign hit = {(state_d != IDLE) & oor_d, state_d == AES_WR, state_d == AES_RD,
                state_d == VGA_RD};

  // An access landing on frame_start belongs to the frame that is starting.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = sat_inc(frame_start ? 16'd0 : cnt_q[i], hit[i]);
      out_d[i] = frame_start ? cnt_q[i] : out_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign vga_cnt    = out_q[0];
  assign aes_rd_cnt = out_q[1];
  assign aes_wr_cnt = out_q[2];
  assign drop_cnt   = out_q[3];
`endif

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Directed bench for img_mem_arbiter with a behavioural 1-cycle RAM whose
// unwritten locations read back as the low address byte.
module tb_img_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_req;
  logic [14:0] vga_addr;
  logic [7:0]  vga_data;
  logic        vga_valid;
  logic        aes_req;
  logic        aes_we;
  logic [14:0] aes_addr;
  logic [7:0]  aes_wdata;
  logic        aes_gnt;
  logic [7:0]  aes_rdata;
  logic        aes_rvalid;
  logic        aes_starve;
  logic        stat_clr;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
`ifdef IMG_ARB_STATS_EN
  logic        frame_start;
  logic [15:0] vga_cnt, aes_rd_cnt, aes_wr_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  img_mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_data   (vga_data),
    .vga_valid  (vga_valid),
    .aes_req    (aes_req),
    .aes_we     (aes_we),
    .aes_addr   (aes_addr),
    .aes_wdata  (aes_wdata),
    .aes_gnt    (aes_gnt),
    .aes_rdata  (aes_rdata),
    .aes_rvalid (aes_rvalid),
    .aes_starve (aes_starve),
    .stat_clr   (stat_clr),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef IMG_ARB_STATS_EN
    ,
    .frame_start(frame_start),
    .vga_cnt    (vga_cnt),
    .aes_rd_cnt (aes_rd_cnt),
    .aes_wr_cnt (aes_wr_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  bit [7:0] ram [int];

  always @(posedge clk) begin
    mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : mem_addr[7:0];
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [14:0] vaddr [3];
  logic [7:0]  vexp  [3];
  logic        exp_v;

  initial begin
    vaddr[0] = 15'd0;    vaddr[1] = 15'd100;  vaddr[2] = 15'd30624;
    vexp[0]  = 8'h00;    vexp[1]  = 8'h64;    vexp[2]  = 8'hA0;
    rst_n = 1'b0; vga_req = 1'b0; vga_addr = '0; aes_req = 1'b0; aes_we = 1'b0;
    aes_addr = '0; aes_wdata = '0; stat_clr = 1'b0;
`ifdef IMG_ARB_STATS_EN
    frame_start = 1'b0;
`endif
    tick; tick;

    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_vga_data", vga_data, 0);
    check("rst_vga_valid", vga_valid, 0);
    check("rst_aes_rdata", aes_rdata, 0);
    check("rst_aes_rvalid", aes_rvalid, 0);
    check("rst_aes_starve", aes_starve, 0);
    aes_req = 1'b1;
    #1 check("rst_aes_gnt", aes_gnt, 0);
    aes_req = 1'b0;
    rst_n = 1'b1;
    tick;

    // VGA reads every other cycle with AES requesting in the background
    for (int c = 0; c < 9; c++) begin
      exp_v = (c >= 3 && c <= 7 && ((c - 3) % 2 == 0));
      check("vga_valid_seq", vga_valid, exp_v);
      if (exp_v) check("vga_data_seq", vga_data, vexp[(c-3)/2]);
      vga_req = (c <= 4 && (c % 2) == 0);
      if (vga_req) vga_addr = vaddr[c/2];
      aes_req = 1'b1; aes_we = 1'b0; aes_addr = 15'd7;
      #1 check("aes_gnt_seq", aes_gnt, !vga_req);
      tick;
    end
    aes_req = 1'b0; vga_req = 1'b0;
    tick; tick; tick; tick;

    // collision: VGA wins, AES granted next cycle
    vga_req = 1'b1; vga_addr = 15'd10;
    aes_req = 1'b1; aes_we = 1'b0; aes_addr = 15'd5;
    #1 check("col_gnt0", aes_gnt, 0);
    tick;
    vga_req = 1'b0;
    #1 check("col_gnt1", aes_gnt, 1);
    tick;
    aes_req = 1'b0;
    tick;
    check("col_vga_valid", vga_valid, 1);
    check("col_vga_data", vga_data, 8'h0A);
    check("col_aes_rvalid_early", aes_rvalid, 0);
    tick;
    check("col_aes_rvalid", aes_rvalid, 1);
    check("col_aes_rdata", aes_rdata, 8'h05);
    check("col_vga_valid_off", vga_valid, 0);
    tick; tick;

    // AES write then read back
    aes_req = 1'b1; aes_we = 1'b1; aes_addr = 15'd200; aes_wdata = 8'h3C;
    #1 check("wr_gnt", aes_gnt, 1);
    tick;
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 200);
    check("wr_mem_wdata", mem_wdata, 8'h3C);
    aes_we = 1'b0;
    tick;
    aes_req = 1'b0;
    check("rd_mem_we", mem_we, 0);
    tick; tick;
    check("rd_aes_rvalid", aes_rvalid, 1);
    check("rd_aes_rdata", aes_rdata, 8'h3C);

    aes_req = 1'b1; aes_we = 1'b1; aes_addr = 15'd0; aes_wdata = 8'h5A;
    tick;
    aes_req = 1'b0;
    tick; tick;

    // out-of-range write dropped, out-of-range read returns zero
    aes_req = 1'b1; aes_we = 1'b1; aes_addr = 15'd30625; aes_wdata = 8'hFF;
    #1 check("oor_wr_gnt", aes_gnt, 1);
    tick;
    check("oor_wr_mem_we", mem_we, 0);
    aes_we = 1'b0; aes_addr = 15'd32767;
    tick;
    check("oor_rd_mem_addr", mem_addr, 0);
    aes_req = 1'b0;
    tick; tick;
    check("oor_rd_rvalid", aes_rvalid, 1);
    check("oor_rd_rdata", aes_rdata, 0);
    tick; tick;

    // starvation under continuous VGA traffic
    aes_req = 1'b1; aes_we = 1'b0; aes_addr = 15'd1;
    vga_req = 1'b1; vga_addr = 15'd2;
    for (int n = 0; n < 63; n++) tick;
    check("starve_63", aes_starve, 0);
    tick;
    check("starve_64", aes_starve, 1);
    for (int n = 0; n < 6; n++) tick;
    vga_req = 1'b0;
    #1 check("starve_gnt_after", aes_gnt, 1);
    tick;
    aes_req = 1'b0;
    tick; tick; tick;
    check("starve_sticky", aes_starve, 1);
    stat_clr = 1'b1;
    tick;
    stat_clr = 1'b0;
    check("starve_clr", aes_starve, 0);

    // reset one cycle after a VGA issue
    vga_req = 1'b1; vga_addr = 15'd100;
    tick;
    vga_req = 1'b0; rst_n = 1'b0;
    aes_req = 1'b1; aes_we = 1'b0; aes_addr = 15'd3;
    #1 check("mrst_aes_gnt", aes_gnt, 0);
    tick;
    check("mrst_mem_addr", mem_addr, 0);
    check("mrst_mem_we", mem_we, 0);
    check("mrst_vga_data", vga_data, 0);
    check("mrst_aes_rdata", aes_rdata, 0);
    check("mrst_aes_starve", aes_starve, 0);
    rst_n = 1'b1; aes_req = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick;
      check("mrst_vga_valid", vga_valid, 0);
      check("mrst_aes_rvalid", aes_rvalid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
